// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, instruction classes, immediate formats.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    CLS_LUI     = 4'd0,
    CLS_AUIPC   = 4'd1,
    CLS_JAL     = 4'd2,
    CLS_JALR    = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_OPIMM   = 4'd7,
    CLS_OP      = 4'd8,
    CLS_FENCE   = 4'd9,
    CLS_SYSTEM  = 4'd10,
    CLS_ILLEGAL = 4'd11
  } ex_class_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  // Sign-extended immediate for a given format; R-type and illegal give zero.
  function automatic logic [31:0] build_imm(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I decoder: class, register enables, rd write flag, immediate.
module rv32i_decoder
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  cls,
  output logic        rs1_en,
  output logic        rs2_en,
  output logic        rd_we,
  output logic [31:0] imm,
  output logic        illegal
);

  ex_class_e cls_c;
  imm_fmt_e  fmt_c;
  logic      writes_rd;

  // Opcode lookup; anything not recognised (or a compressed encoding) stays ILLEGAL.
  always_comb begin
    cls_c     = CLS_ILLEGAL;
    fmt_c     = IMM_NONE;
    rs1_en    = 1'b0;
    rs2_en    = 1'b0;
    writes_rd = 1'b0;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:0])
        OPC_LUI:    begin cls_c = CLS_LUI;    fmt_c = IMM_U; writes_rd = 1'b1; end
        OPC_AUIPC:  begin cls_c = CLS_AUIPC;  fmt_c = IMM_U; writes_rd = 1'b1; end
        OPC_JAL:    begin cls_c = CLS_JAL;    fmt_c = IMM_J; writes_rd = 1'b1; end
        OPC_JALR:   begin cls_c = CLS_JALR;   fmt_c = IMM_I; writes_rd = 1'b1; rs1_en = 1'b1; end
        OPC_BRANCH: begin cls_c = CLS_BRANCH; fmt_c = IMM_B; rs1_en = 1'b1; rs2_en = 1'b1; end
        OPC_LOAD:   begin cls_c = CLS_LOAD;   fmt_c = IMM_I; writes_rd = 1'b1; rs1_en = 1'b1; end
        OPC_STORE:  begin cls_c = CLS_STORE;  fmt_c = IMM_S; rs1_en = 1'b1; rs2_en = 1'b1; end
        OPC_OPIMM:  begin cls_c = CLS_OPIMM;  fmt_c = IMM_I; writes_rd = 1'b1; rs1_en = 1'b1; end
        OPC_OP:     begin cls_c = CLS_OP;     writes_rd = 1'b1; rs1_en = 1'b1; rs2_en = 1'b1; end
        OPC_FENCE:  begin cls_c = CLS_FENCE;  fmt_c = IMM_I; end
        OPC_SYSTEM: begin cls_c = CLS_SYSTEM; fmt_c = IMM_I; end
        default:    begin cls_c = CLS_ILLEGAL; end
      endcase
    end
  end

  assign cls     = cls_c;
  assign illegal = (cls_c == CLS_ILLEGAL);
  // Writes to x0 are architecturally discarded, so never track them.
  assign rd_we   = writes_rd & (instr[11:7] != 5'd0);
  assign imm     = build_imm(instr, fmt_c);

endmodule

// File: rtl/id_stage.sv
// RV32I decode/issue stage: RF read addressing, register scoreboard, ID/EX register.
module id_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  output logic            rf_rs1_en,
  output logic            rf_rs2_en,
  input  logic [XLEN-1:0] rf_rs1_val,
  input  logic [XLEN-1:0] rf_rs2_val,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic            ex_rd_we,
  output logic [3:0]      ex_class,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_illegal
);

  logic [3:0]  dec_cls;
  logic        dec_rd_we;
  logic [31:0] dec_imm;
  logic        dec_illegal;
  logic [4:0]  dec_rd;

  logic [31:0] busy_reg;
  logic [31:0] busy_next;
  logic [31:0] pend_vec;
  logic        ex_fire;
  logic        hazard;
  logic        capture;

  rv32i_decoder u_decoder (
    .instr   (if_instr),
    .cls     (dec_cls),
    .rs1_en  (rf_rs1_en),
    .rs2_en  (rf_rs2_en),
    .rd_we   (dec_rd_we),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  assign rf_rs1 = if_instr[19:15];
  assign rf_rs2 = if_instr[24:20];
  assign dec_rd = if_instr[11:7];

  assign ex_fire = ex_valid & ex_ready;

  // Per-register scoreboard update: a retiring issue (set) beats a same-cycle writeback (clear).
  assign busy_next[0] = 1'b0;
  assign pend_vec[0]  = 1'b0;
  for (genvar gi = 1; gi < 32; gi++) begin : g_busy
    assign busy_next[gi] = (ex_fire & ex_rd_we & (ex_rd == 5'(gi)))
                         | (busy_reg[gi] & ~(wb_valid & (wb_rd == 5'(gi))));
    // Pending also covers the writer still sitting in ID/EX, not yet in the scoreboard.
    assign pend_vec[gi]  = busy_reg[gi] | (ex_valid & ex_rd_we & (ex_rd == 5'(gi)));
  end

  // RAW on either source plus WAW on rd, so each register has at most one write in flight.
  assign hazard = (rf_rs1_en & pend_vec[rf_rs1])
                | (rf_rs2_en & pend_vec[rf_rs2])
                | (dec_rd_we & pend_vec[dec_rd]);

  assign if_ready = reset & (~ex_valid | ex_ready) & ~hazard & ~flush;
  assign capture  = if_valid & if_ready;

  // Scoreboard register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_reg <= 32'd0;
    else        busy_reg <= busy_next;
  end

  // ID/EX register: load on capture, drain on handshake or flush, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_val  <= '0;
      ex_rs2_val  <= '0;
      ex_imm      <= '0;
      ex_rd       <= 5'd0;
      ex_rd_we    <= 1'b0;
      ex_class    <= 4'd0;
      ex_funct3   <= 3'd0;
      ex_funct7b5 <= 1'b0;
      ex_illegal  <= 1'b0;
    end else if (capture) begin
      ex_valid    <= 1'b1;
      ex_pc       <= if_pc;
      ex_rs1_val  <= rf_rs1_val;
      ex_rs2_val  <= rf_rs2_val;
      ex_imm      <= dec_imm;
      ex_rd       <= dec_rd;
      ex_rd_we    <= dec_rd_we;
      ex_class    <= dec_cls;
      ex_funct3   <= if_instr[14:12];
      ex_funct7b5 <= if_instr[30];
      ex_illegal  <= dec_illegal;
    end else if (ex_ready || flush) begin
      ex_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: expectations queued at acceptance, compared at ex handshake.
module tb_id_stage;
  import rv32i_pkg::*;

  logic        clk;
  logic        reset;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [4:0]  rf_rs1, rf_rs2;
  logic        rf_rs1_en, rf_rs2_en;
  logic [31:0] rf_rs1_val, rf_rs2_val;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_rd_we;
  logic [3:0]  ex_class;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic        ex_illegal;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs1v;
    logic [31:0] rs2v;
    logic [31:0] imm;
    logic [3:0]  cls;
    logic        en1;
    logic        en2;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  exp_t got;

  logic [31:0] regs [32];

  assign rf_rs1_val = regs[rf_rs1];
  assign rf_rs2_val = regs[rf_rs2];

  id_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .rf_rs1      (rf_rs1),
    .rf_rs2      (rf_rs2),
    .rf_rs1_en   (rf_rs1_en),
    .rf_rs2_en   (rf_rs2_en),
    .rf_rs1_val  (rf_rs1_val),
    .rf_rs2_val  (rf_rs2_val),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_pc       (ex_pc),
    .ex_rs1_val  (ex_rs1_val),
    .ex_rs2_val  (ex_rs2_val),
    .ex_imm      (ex_imm),
    .ex_rd       (ex_rd),
    .ex_rd_we    (ex_rd_we),
    .ex_class    (ex_class),
    .ex_funct3   (ex_funct3),
    .ex_funct7b5 (ex_funct7b5),
    .ex_illegal  (ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] imm, input logic [3:0] cls,
                              input logic en1, input logic en2, input logic we, input logic ill);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    e.rs1v  = regs[instr[19:15]];
    e.rs2v  = regs[instr[24:20]];
    e.imm   = imm;
    e.cls   = cls;
    e.en1   = en1;
    e.en2   = en2;
    e.we    = we;
    e.ill   = ill;
    return e;
  endfunction

  // Monitor: retire the held instruction first, then queue a newly accepted one.
  always @(negedge clk) begin
    if (reset) begin
      if (ex_valid && (ex_ready || flush)) begin
        if (exp_q.size() == 0) begin
          check_eq("ex_unexpected", 32'd1, 32'd0);
        end else begin
          got = exp_q.pop_front();
          check_eq("ex_pc",      ex_pc,               got.pc);
          check_eq("ex_rs1_val", ex_rs1_val,          got.rs1v);
          check_eq("ex_rs2_val", ex_rs2_val,          got.rs2v);
          check_eq("ex_imm",     ex_imm,              got.imm);
          check_eq("ex_class",   32'(ex_class),       32'(got.cls));
          check_eq("ex_rd",      32'(ex_rd),          32'(got.instr[11:7]));
          check_eq("ex_rd_we",   32'(ex_rd_we),       32'(got.we));
          check_eq("ex_funct3",  32'(ex_funct3),      32'(got.instr[14:12]));
          check_eq("ex_f7b5",    32'(ex_funct7b5),    32'(got.instr[30]));
          check_eq("ex_illegal", 32'(ex_illegal),     32'(got.ill));
          $display("txn pc=%h instr=%h class=%0d imm=%h rd=%0d we=%0d", ex_pc, got.instr,
                   ex_class, ex_imm, ex_rd, ex_rd_we);
        end
      end
      if (if_valid && if_ready) begin
        check_eq("rf_rs1",    32'(rf_rs1),    32'(cur.instr[19:15]));
        check_eq("rf_rs2",    32'(rf_rs2),    32'(cur.instr[24:20]));
        check_eq("rf_rs1_en", 32'(rf_rs1_en), 32'(cur.en1));
        check_eq("rf_rs2_en", 32'(rf_rs2_en), 32'(cur.en2));
        exp_q.push_back(cur);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input exp_t e);
    cur      = e;
    if_instr = e.instr;
    if_pc    = e.pc;
    if_valid = 1'b1;
  endtask

  // Bounded wait for acceptance; drops if_valid once the capturing edge has passed.
  task automatic wait_accept(input int max_wait, input string tag);
    int n = 0;
    @(negedge clk);
    while (!if_ready && n < max_wait) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_accept"}, 32'(if_ready), 32'd1);
    tick();
    if_valid = 1'b0;
  endtask

  task automatic hold_ready(input string tag, input logic expv, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq(tag, 32'(if_ready), 32'(expv));
      tick();
    end
  endtask

  task automatic writeback(input logic [4:0] rd);
    wb_valid = 1'b1;
    wb_rd    = rd;
    tick();
    wb_valid = 1'b0;
    wb_rd    = 5'd0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : (32'h1000_0000 | (i << 8) | i);
    reset    = 1'b0;
    if_valid = 1'b0;
    if_instr = 32'd0;
    if_pc    = 32'd0;
    wb_valid = 1'b0;
    wb_rd    = 5'd0;
    flush    = 1'b0;
    ex_ready = 1'b1;

    #3;
    check_eq("rst_ex_valid", 32'(ex_valid), 32'd0);
    check_eq("rst_if_ready", 32'(if_ready), 32'd0);
    check_eq("rst_ex_pc",    ex_pc,         32'd0);
    tick();
    reset = 1'b1;

    // Basic decode, then RAW stall on x1 until its writeback.
    send(mk(32'h100, 32'h00500093, 32'd5, CLS_OPIMM, 1'b1, 1'b0, 1'b1, 1'b0));
    wait_accept(0, "addi_x1");
    send(mk(32'h104, 32'h00108133, 32'd0, CLS_OP, 1'b1, 1'b1, 1'b1, 1'b0));
    hold_ready("raw_stall", 1'b0, 3);
    wb_valid = 1'b1;
    wb_rd    = 5'd1;
    @(negedge clk);
    check_eq("raw_no_bypass", 32'(if_ready), 32'd0);
    tick();
    wb_valid = 1'b0;
    wait_accept(0, "raw_release");

    // x0 destination is untracked; back-to-back issue with no bubble.
    send(mk(32'h108, 32'h00100013, 32'd1, CLS_OPIMM, 1'b1, 1'b0, 1'b0, 1'b0));
    wait_accept(0, "addi_x0");
    send(mk(32'h10C, 32'h000001B3, 32'd0, CLS_OP, 1'b1, 1'b1, 1'b1, 1'b0));
    wait_accept(0, "use_x0");
    writeback(5'd2);

    // Store immediate.
    send(mk(32'h110, 32'hFE20AE23, 32'hFFFFFFFC, CLS_STORE, 1'b1, 1'b1, 1'b0, 1'b0));
    wait_accept(0, "sw");
    tick();

    // Backpressure holds ex_* stable, then a flush alongside the releasing handshake.
    ex_ready = 1'b0;
    send(mk(32'h114, 32'h123452B7, 32'h12345000, CLS_LUI, 1'b0, 1'b0, 1'b1, 1'b0));
    wait_accept(0, "lui_x5");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_ex_valid", 32'(ex_valid), 32'd1);
      check_eq("bp_ex_imm",   ex_imm,        32'h12345000);
      check_eq("bp_ex_pc",    ex_pc,         32'h114);
      check_eq("bp_ex_rd",    32'(ex_rd),    32'd5);
      check_eq("bp_if_ready", 32'(if_ready), 32'd0);
      tick();
    end
    ex_ready = 1'b1;
    flush    = 1'b1;
    send(mk(32'h118, 32'h008000EF, 32'd8, CLS_JAL, 1'b0, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    check_eq("flush_blocks", 32'(if_ready), 32'd0);
    tick();
    flush    = 1'b0;
    if_valid = 1'b0;
    @(negedge clk);
    check_eq("flush_drops", 32'(ex_valid), 32'd0);
    tick();
    // The flushed-but-handshaken lui still marked x5 busy.
    send(mk(32'h11C, 32'h00028313, 32'd0, CLS_OPIMM, 1'b1, 1'b0, 1'b1, 1'b0));
    hold_ready("x5_busy", 1'b0, 2);
    writeback(5'd5);
    wait_accept(0, "x5_release");

    // Branch, jump and an illegal word.
    send(mk(32'h120, 32'hFE208CE3, 32'hFFFFFFF8, CLS_BRANCH, 1'b1, 1'b1, 1'b0, 1'b0));
    wait_accept(0, "beq");
    send(mk(32'h124, 32'h008000EF, 32'd8, CLS_JAL, 1'b0, 1'b0, 1'b1, 1'b0));
    wait_accept(0, "jal");
    send(mk(32'h128, 32'hFFFFFFFF, 32'd0, CLS_ILLEGAL, 1'b0, 1'b0, 1'b0, 1'b1));
    wait_accept(0, "illegal");
    writeback(5'd1);
    writeback(5'd3);
    writeback(5'd6);

    // Build busy = {x2,x1} with an instruction held, then reset asynchronously.
    send(mk(32'h200, 32'h00500093, 32'd5, CLS_OPIMM, 1'b1, 1'b0, 1'b1, 1'b0));
    wait_accept(0, "pre_rst_x1");
    send(mk(32'h204, 32'h00700113, 32'd7, CLS_OPIMM, 1'b1, 1'b0, 1'b1, 1'b0));
    wait_accept(0, "pre_rst_x2");
    send(mk(32'h208, 32'h000003B7, 32'd0, CLS_LUI, 1'b0, 1'b0, 1'b1, 1'b0));
    wait_accept(0, "pre_rst_x7");
    ex_ready = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check_eq("arst_ex_valid", 32'(ex_valid), 32'd0);
    check_eq("arst_ex_imm",   ex_imm,        32'd0);
    check_eq("arst_ex_pc",    ex_pc,         32'd0);
    check_eq("arst_ex_rd_we", 32'(ex_rd_we), 32'd0);
    check_eq("arst_if_ready", 32'(if_ready), 32'd0);
    exp_q.delete();
    tick();
    reset    = 1'b1;
    ex_ready = 1'b1;
    // Would stall if busy[1] or busy[2] survived reset.
    send(mk(32'h300, 32'h002081B3, 32'd0, CLS_OP, 1'b1, 1'b1, 1'b1, 1'b0));
    wait_accept(0, "post_rst");
    tick();
    tick();
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
